mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
MEM/WB pipeline register plus writeback unit; the producing end of the register-file write port that id_stage consumes (i_reg_write / i_write_register / i_write_data).
- Latches MEM-stage results each cycle.
- Sign/zero-extends load data by type and byte offset.
- Selects ALU result vs load data; suppresses writes to $0.
- Supports stall (hold) and flush (bubble); keeps a retired-instruction counter for debug/verification.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported.
REG_ADDR_WIDTH, 5, register index width.
RETIRE_CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; state cleared while reset==0
i_valid  input  1  MEM stage holds a real instruction
i_stall  input  1  hold all stage registers this cycle
i_flush  input  1  load a bubble this cycle
i_reg_write  input  1  instruction writes a register
i_mem_to_reg  input  1  1: writeback data from memory, 0: from ALU
i_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes = LW
i_alu_result  input  32  ALU result; bits [1:0] are the load byte offset
i_mem_read_data  input  32  raw aligned memory word
i_write_register  input  5  destination register index
o_valid  output  1  registered valid
o_reg_write  output  1  to ID register bank write enable
o_write_register  output  5  to ID register bank write address
o_write_data  output  32  to ID register bank write data
o_retired_count  output  RETIRE_CNT_WIDTH  valid instructions retired

Behaviour:
- Reset (reset==0, asynchronous): all outputs and internal registers are 0. Outputs stay 0 until the first rising edge after reset==1.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority: flush > stall > normal capture.
  - Flush: o_valid=0, o_reg_write=0, o_write_register=0, o_write_data=0. Counter is not incremented. Flush overrides a simultaneous stall.
  - Stall (no flush): every register holds its value. While stalled, o_reg_write stays at its held value; the repeated register-file write is idempotent and is permitted. Counter does not increment.
  - Normal capture:
    - o_valid <= i_valid.
    - o_write_register <= i_write_register.
    - o_reg_write <= i_valid & i_reg_write & (i_write_register != 0).
    - o_write_data <= i_mem_to_reg ? ext_data : i_alu_result.
- Load extension (combinational, before the register), little-endian; byte k = i_mem_read_data[8k+7:8k], k = i_alu_result[1:0].
  - LB: sign-extend byte k.
  - LBU: zero-extend byte k.
  - LH: sign-extend halfword at bits [16h+15:16h], h = i_alu_result[1]; i_alu_result[0] is ignored (no misalignment trap).
  - LHU: as LH, zero-extended.
  - LW / other codes: whole word; offset ignored.
- Data when i_valid==0: o_write_data and o_write_register still capture, but o_reg_write is 0.
- Retired counter: increments by 1 on a normal capture with i_valid==1, whether or not the instruction writes a register. Wraps modulo 2^RETIRE_CNT_WIDTH with no saturation.
- Register 0: never written. o_reg_write is 0 whenever the destination is 0, regardless of i_reg_write.
- No combinational path from any input to any output.

Test Plan:
- Load extension: i_mem_read_data=0x80FF1234, i_alu_result=0x...03, mem_to_reg=1, rt=8, valid, reg_write.
  - LB -> o_write_data=0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH with offset 2 -> 0xFFFF80FF.
  - LHU with offset 2 -> 0x000080FF.
  - LW -> 0x80FF1234.
- ALU path: mem_to_reg=0, alu_result=0x00000042, rd=3 -> next cycle o_reg_write=1, o_write_register=3, o_write_data=0x42; o_retired_count goes 0->1.
- $0 suppression: reg_write=1, i_write_register=0, alu_result=0xDEADBEEF -> o_reg_write=0; counter still increments.
- Stall then flush:
  - Capture instr A (rd=5, data=7), then stall 3 cycles while inputs change -> outputs stay A, counter unchanged.
  - Assert stall+flush together -> o_valid=0, o_reg_write=0, counter unchanged.
- Reset mid-operation: drive reset=0 asynchronously between edges while o_reg_write=1 -> all outputs 0 immediately (before the next edge). Release reset -> first capture after the next edge.
- Counter wrap: RETIRE_CNT_WIDTH=4, retire 17 valid instructions back-to-back -> o_retired_count=1.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback
//
// MEM/WB pipeline register combined with the writeback unit. It is the
// producing end of the register-file write port (reg_write / write_register /
// write_data) consumed by the ID stage.
//
//   - Latches MEM-stage results every rising edge (1-cycle latency).
//   - Extends load data by load type and byte offset before the register.
//   - Selects ALU result vs. extended load data.
//   - Never enables a write to register 0.
//   - Stall holds every register; flush loads a bubble (flush wins).
//   - Keeps a wrapping count of retired valid instructions.
//
// Ports
//   clk                clock, all state on the rising edge
//   reset              asynchronous, active-low reset
//   i_valid            MEM stage holds a real instruction
//   i_stall            hold all stage registers this cycle
//   i_flush            load a bubble this cycle
//   i_reg_write        instruction writes a register
//   i_mem_to_reg       1: writeback from memory, 0: from ALU
//   i_load_type        000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, other = LW
//   i_alu_result       ALU result; bits [1:0] are the load byte offset
//   i_mem_read_data    raw aligned memory word
//   i_write_register   destination register index
//   o_valid            registered valid
//   o_reg_write        register-bank write enable
//   o_write_register   register-bank write address
//   o_write_data       register-bank write data
//   o_retired_count    number of valid instructions retired (wraps)
// -----------------------------------------------------------------------------
module mem_wb_writeback #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RETIRE_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic                        i_reg_write,
    input  logic                        i_mem_to_reg,
    input  logic [2:0]                  i_load_type,
    input  logic [DATA_WIDTH-1:0]       i_alu_result,
    input  logic [DATA_WIDTH-1:0]       i_mem_read_data,
    input  logic [REG_ADDR_WIDTH-1:0]   i_write_register,
    output logic                        o_valid,
    output logic                        o_reg_write,
    output logic [REG_ADDR_WIDTH-1:0]   o_write_register,
    output logic [DATA_WIDTH-1:0]       o_write_data,
    output logic [RETIRE_CNT_WIDTH-1:0] o_retired_count
);

    // Load type encodings
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    // Little-endian load extension. The byte lane comes from offset[1:0],
    // the halfword lane from offset[1] only (offset[0] is ignored for
    // halfwords; misaligned halfwords are not trapped here).
    function automatic logic [31:0] load_extend(
        input logic [2:0]  load_type,
        input logic [31:0] word,
        input logic [1:0]  offset
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        if (offset[1]) begin
            half_sel = word[31:16];
        end else begin
            half_sel = word[15:0];
        end
        case (load_type)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {24'h000000, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {16'h0000, half_sel};
            LT_LW:   result = word;
            default: result = word;
        endcase
        return result;
    endfunction

    logic [DATA_WIDTH-1:0]       w_ext_data;
    logic [DATA_WIDTH-1:0]       w_wb_data;
    logic                        w_reg_write;

    logic                        r_valid;
    logic                        r_reg_write;
    logic [REG_ADDR_WIDTH-1:0]   r_write_register;
    logic [DATA_WIDTH-1:0]       r_write_data;
    logic [RETIRE_CNT_WIDTH-1:0] r_retired_count;

    assign w_ext_data  = load_extend(i_load_type, i_mem_read_data, i_alu_result[1:0]);
    assign w_wb_data   = i_mem_to_reg ? w_ext_data : i_alu_result;
    // Register 0 is hard-wired, so a write enable to it is never issued.
    assign w_reg_write = i_valid & i_reg_write & (i_write_register != {REG_ADDR_WIDTH{1'b0}});

    // Pipeline register with flush > stall > capture priority and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid          <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= {REG_ADDR_WIDTH{1'b0}};
            r_write_data     <= {DATA_WIDTH{1'b0}};
            r_retired_count  <= {RETIRE_CNT_WIDTH{1'b0}};
        end else if (i_flush) begin
            // Bubble: nothing retires, counter holds.
            r_valid          <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= {REG_ADDR_WIDTH{1'b0}};
            r_write_data     <= {DATA_WIDTH{1'b0}};
            r_retired_count  <= r_retired_count;
        end else if (i_stall) begin
            // Held write enable repeats the same register-file write,
            // which is harmless.
            r_valid          <= r_valid;
            r_reg_write      <= r_reg_write;
            r_write_register <= r_write_register;
            r_write_data     <= r_write_data;
            r_retired_count  <= r_retired_count;
        end else begin
            r_valid          <= i_valid;
            r_reg_write      <= w_reg_write;
            r_write_register <= i_write_register;
            r_write_data     <= w_wb_data;
            if (i_valid) begin
                r_retired_count <= r_retired_count + {{(RETIRE_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_retired_count <= r_retired_count;
            end
        end
    end

    assign o_valid          = r_valid;
    assign o_reg_write      = r_reg_write;
    assign o_write_register = r_write_register;
    assign o_write_data     = r_write_data;
    assign o_retired_count  = r_retired_count;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_writeback
//
// Self-checking bench for mem_wb_writeback. Directed cases cover the load
// extension table, ALU path, $0 suppression, stall/flush, asynchronous reset
// and counter wrap (a second instance with a 4-bit counter); a randomized
// phase follows. Expected values come from a behavioural model below.
// -----------------------------------------------------------------------------
module tb_mem_wb_writeback;

    logic        clk;
    logic        reset;
    logic        valid;
    logic        stall;
    logic        flush;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  wreg;

    logic        o_valid;
    logic        o_reg_write;
    logic [4:0]  o_write_register;
    logic [31:0] o_write_data;
    logic [31:0] o_retired_count;

    logic        o4_valid;
    logic        o4_reg_write;
    logic [4:0]  o4_write_register;
    logic [31:0] o4_write_data;
    logic [3:0]  o4_retired_count;

    int n_checks;
    int n_fail;

    // Behavioural model state
    bit          m_valid;
    bit          m_rw;
    int unsigned m_wr;
    int unsigned m_wd;
    int unsigned m_cnt;
    int unsigned m_cnt4;

    mem_wb_writeback #(.RETIRE_CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_reg_write(rw), .i_mem_to_reg(m2r), .i_load_type(lt), .i_alu_result(alu),
        .i_mem_read_data(mem), .i_write_register(wreg),
        .o_valid(o_valid), .o_reg_write(o_reg_write), .o_write_register(o_write_register),
        .o_write_data(o_write_data), .o_retired_count(o_retired_count)
    );

    mem_wb_writeback #(.RETIRE_CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_reg_write(rw), .i_mem_to_reg(m2r), .i_load_type(lt), .i_alu_result(alu),
        .i_mem_read_data(mem), .i_write_register(wreg),
        .o_valid(o4_valid), .o_reg_write(o4_reg_write), .o_write_register(o4_write_register),
        .o_write_data(o4_write_data), .o_retired_count(o4_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference load extension written with plain arithmetic.
    function automatic int unsigned ref_ext(input int unsigned t, input int unsigned w,
                                            input int unsigned off);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        if (t == 0) return (b >= 128) ? b + 32'hFFFFFF00 : b;
        if (t == 4) return b;
        if (t == 1) return (h >= 32768) ? h + 32'hFFFF0000 : h;
        if (t == 5) return h;
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_wr = 0; m_wd = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_wr = 0; m_wd = 0;
        end else if (!stall) begin
            m_valid = valid;
            m_wr    = wreg;
            m_rw    = valid && rw && (wreg != 0);
            m_wd    = m2r ? ref_ext(lt, mem, alu % 4) : alu;
            if (valid) begin
                m_cnt  = m_cnt + 1;
                m_cnt4 = (m_cnt4 + 1) % 16;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, m_valid});
        check({tag, ".reg_write"}, {31'd0, o_reg_write}, {31'd0, m_rw});
        check({tag, ".wreg"}, {27'd0, o_write_register}, m_wr);
        check({tag, ".wdata"}, o_write_data, m_wd);
        check({tag, ".count"}, o_retired_count, m_cnt);
        check({tag, ".count4"}, {28'd0, o4_retired_count}, m_cnt4);
    endtask

    // One clock: model updates with the inputs sampled at the edge, outputs
    // are checked on the following falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic set_in(input bit v, input bit r, input bit mr, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] m, input logic [4:0] d);
        valid = v; rw = r; m2r = mr; lt = t; alu = a; mem = m; wreg = d;
    endtask

    initial begin
        logic [2:0]  ltab [5];
        logic [31:0] xtab [5];
        int unsigned saved_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd7);
        model_reset();

        // Reset holds outputs at zero even while edges arrive.
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        reset = 1'b1;

        // Load extension table
        ltab[0] = 3'b000; xtab[0] = 32'hFFFF_FF80;
        ltab[1] = 3'b100; xtab[1] = 32'h0000_0080;
        ltab[2] = 3'b001; xtab[2] = 32'hFFFF_80FF;
        ltab[3] = 3'b101; xtab[3] = 32'h0000_80FF;
        ltab[4] = 3'b010; xtab[4] = 32'h80FF_1234;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 1'b1, ltab[i], 32'h0000_0103, 32'h80FF_1234, 5'd8);
            cycle("load");
            check("load_const", o_write_data, xtab[i]);
        end

        // ALU path
        saved_cnt = o_retired_count;
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0042, 32'hFFFF_FFFF, 5'd3);
        cycle("alu");
        check("alu_rw", {31'd0, o_reg_write}, 32'd1);
        check("alu_wreg", {27'd0, o_write_register}, 32'd3);
        check("alu_data", o_write_data, 32'h0000_0042);
        check("alu_cnt", o_retired_count, saved_cnt + 32'd1);

        // Register 0 suppression
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 32'hDEAD_BEEF, 32'h0, 5'd0);
        cycle("r0");
        check("r0_rw", {31'd0, o_reg_write}, 32'd0);
        check("r0_cnt", o_retired_count, saved_cnt + 32'd2);

        // Invalid instruction still captures data but never writes
        set_in(1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_0055, 32'h0, 5'd9);
        cycle("inval");
        check("inval_rw", {31'd0, o_reg_write}, 32'd0);
        check("inval_data", o_write_data, 32'h0000_0055);

        // Stall then stall+flush
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0007, 32'h0, 5'd5);
        cycle("capA");
        saved_cnt = o_retired_count;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, $urandom_range(0, 1), 3'($urandom), $urandom, $urandom, 5'($urandom));
            cycle("stall");
            check("stall_data", o_write_data, 32'd7);
            check("stall_wreg", {27'd0, o_write_register}, 32'd5);
            check("stall_cnt", o_retired_count, saved_cnt);
        end
        flush = 1'b1;
        cycle("flush");
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_rw", {31'd0, o_reg_write}, 32'd0);
        check("flush_cnt", o_retired_count, saved_cnt);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_1111, 32'h0, 5'd9);
        cycle("prerst");
        check("prerst_rw", {31'd0, o_reg_write}, 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_2222, 32'h0, 5'd4);
        cycle("postrst");
        check("postrst_data", o_write_data, 32'h0000_2222);

        // Counter wrap on the 4-bit instance: 17 retirements from reset -> 1
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'(i % 2), 1'b0, 3'd2, $urandom, 32'h0, 5'($urandom));
            cycle("wrap");
        end
        check("wrap_cnt4", {28'd0, o4_retired_count}, 32'd1);
        check("wrap_cnt32", o_retired_count, 32'd17);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   3'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
